tt_bin_clock_shift_out: RTL and testbench
=========================================

TT_BIN_CLOCK_SHIFT_OUT -- requirements
Module: tt_bin_clock_shift_out

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk_i cycles per sr_clk_o half-period; legal range 1..255.
REQ-002 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port hour_i  input  4  binary hour from the clock core.
REQ-005 SHALL have port minute_i  input  6  binary minute from the clock core.
REQ-006 SHALL have port seconds_i  input  6  binary seconds from the clock core.
REQ-007 SHALL have port refresh_i  input  1  single-cycle request to resend the current time.
REQ-008 SHALL have port sr_data_o  output  1  serial data to external 74HC595 chain.
REQ-009 SHALL have port sr_clk_o  output  1  shift clock to the chain; data sampled externally on its rising edge.
REQ-010 SHALL have port sr_latch_o  output  1  storage-register latch pulse, active-high.
REQ-011 SHALL have port busy_o  output  1  high while a frame is in progress.

Function
REQ-012 SHALL register all four outputs; no combinational path from any input to any output.
REQ-013 SHALL form the 16-bit frame {hour_i, minute_i, seconds_i}, shifted MSB first (hour_i[3] first, seconds_i[0] last).
REQ-014 SHALL use FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
REQ-015 In IDLE: all outputs 0; enter LOAD next cycle if pending flag set, refresh_i high, or the frame differs from last_sent.
REQ-016 LOAD lasts 1 cycle: capture frame into shift register and last_sent, clear pending, set bit counter to 15, busy_o=1.
REQ-017 SHIFT_LO lasts CLK_DIV cycles: sr_clk_o=0, sr_data_o=shift register MSB.
REQ-018 SHIFT_HI lasts CLK_DIV cycles: sr_clk_o=1, sr_data_o held; on exit, if bit counter=0 go to LATCH, else shift left by one, decrement the counter, and go to SHIFT_LO.
REQ-019 LATCH lasts CLK_DIV cycles: sr_latch_o=1, sr_clk_o=0, sr_data_o=0; then IDLE.
REQ-020 busy_o SHALL be 1 in LOAD, SHIFT_LO, SHIFT_HI, and LATCH; a frame occupies exactly 1+33*CLK_DIV cycles (133 at default).
REQ-021 Input changes during a frame SHALL NOT alter the frame in flight; the IDLE comparison picks them up afterwards.
REQ-022 refresh_i asserted while busy_o=1 SHALL set pending; multiple requests collapse into one later frame.
REQ-023 refresh_i coincident with an input change in IDLE SHALL produce exactly one frame.
REQ-024 Input values are passed raw; out-of-range values (e.g. minute_i=63) SHALL be shifted unmodified.
REQ-025 Back-to-back frames SHALL have at least one IDLE cycle between LATCH and LOAD.

Reset
REQ-026 On rstn_i low: state=IDLE; all outputs 0 immediately; shift register, counters, and last_sent = 0; pending = 1.
REQ-027 Reset mid-frame SHALL abort the frame with no latch pulse; after release, a full frame starts from IDLE within 2 cycles.

Structure
REQ-028 Shared package tt_bin_clock_pkg SHALL hold the FSM state typedef and constants HOUR_W=4, MIN_W=6, SEC_W=6, FRAME_W=16.
REQ-029 A single sub-module tt_clk_div_tick (a CLK_DIV down-counter that emits a terminal tick) SHALL time all phases; no other hierarchy.

Verification
REQ-030 Reset release with hour=11, minute=30, seconds=45 -> one frame shifts 0xB7AD (1011 011110 101101), latch pulse width 4, busy high for 133 cycles.
REQ-031 Static inputs after the first frame, no refresh -> no further sr_clk_o edges over 1000 cycles.
REQ-032 seconds_i changes 45->46 mid-frame -> current frame completes with 0xB7AD; next frame carries 0xB7AE.
REQ-033 Three refresh_i pulses while busy -> exactly one extra frame after LATCH.
REQ-034 rstn_i low at bit 7 of a frame -> outputs 0 at once, no latch pulse, full fresh frame after release.
REQ-035 CLK_DIV=1 -> sr_clk_o toggles every cycle; frame length is 34 cycles; captured data matches the frame.

Source files
------------

// File: rtl/tt_bin_clock_pkg.sv
// Shared types and widths for the binary-clock shift-out block.
// The frame is {hour, minute, seconds}, sent MSB first into a 74HC595 chain.
package tt_bin_clock_pkg;

    localparam int HOUR_W  = 4;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int FRAME_W = HOUR_W + MIN_W + SEC_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_t;

endpackage

// File: rtl/tt_clk_div_tick.sv
// Phase timer: reloads to DIV-1 on start and counts down, holding tick high
// once it reaches zero so each phase lasts exactly DIV cycles.
module tt_clk_div_tick
    import tt_bin_clock_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic tick
);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start) begin
            count <= DIV_W'(DIV - 1);
        end else if (count != '0) begin
            count <= count - DIV_W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/tt_bin_clock_shift_out.sv
// Serialises the current time into an external 74HC595 chain whenever it
// changes or a refresh is requested; all outputs come straight from flops.
module tt_bin_clock_shift_out
    import tt_bin_clock_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [HOUR_W-1:0] hour_i,
    input  logic [MIN_W-1:0]  minute_i,
    input  logic [SEC_W-1:0]  seconds_i,
    input  logic             refresh_i,
    output logic             sr_data_o,
    output logic             sr_clk_o,
    output logic             sr_latch_o,
    output logic             busy_o
);

    state_t             state;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] last_sent;
    logic [FRAME_W-2:0] shift_reg;
    logic [BIT_W-1:0]   bit_cnt;
    logic               pending;
    logic               tick;
    logic               div_start;

    assign frame = {hour_i, minute_i, seconds_i};

    // Restart the phase timer on every entry into a timed state.
    always_comb begin
        div_start = 1'b0;
        case (state)
            LOAD:                      div_start = 1'b1;
            SHIFT_LO, SHIFT_HI, LATCH: div_start = tick;
            default:                   div_start = 1'b0;
        endcase
    end

    tt_clk_div_tick #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .start (div_start),
        .tick  (tick)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            shift_reg  <= '0;
            last_sent  <= '0;
            bit_cnt    <= '0;
            pending    <= 1'b1;
            sr_data_o  <= 1'b0;
            sr_clk_o   <= 1'b0;
            sr_latch_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            if (refresh_i && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending || refresh_i || frame != last_sent) begin
                        state  <= LOAD;
                        busy_o <= 1'b1;
                    end
                end
                LOAD: begin
                    // shift_reg holds only the bits still to go; the MSB leaves now
                    shift_reg <= frame[FRAME_W-2:0];
                    last_sent <= frame;
                    pending   <= refresh_i;
                    bit_cnt   <= BIT_W'(FRAME_W - 1);
                    sr_data_o <= frame[FRAME_W-1];
                    sr_clk_o  <= 1'b0;
                    state     <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (tick) begin
                        sr_clk_o <= 1'b1;
                        state    <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        sr_clk_o <= 1'b0;
                        if (bit_cnt == '0) begin
                            sr_data_o  <= 1'b0;
                            sr_latch_o <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            sr_data_o <= shift_reg[FRAME_W-2];
                            shift_reg <= {shift_reg[FRAME_W-3:0], 1'b0};
                            bit_cnt   <= bit_cnt - BIT_W'(1);
                            state     <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        sr_latch_o <= 1'b0;
                        busy_o     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    sr_data_o  <= 1'b0;
                    sr_clk_o   <= 1'b0;
                    sr_latch_o <= 1'b0;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_bin_clock_shift_out.sv
// Bench: models the external 74HC595 chain and compares latched frames, pulse
// widths and frame lengths against the time values that were applied.
module tb_tt_bin_clock_shift_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, refresh;
    logic [3:0] hour;
    logic [5:0] minute, seconds;
    logic       sr_data, sr_clk, sr_latch, busy;

    logic       rstn1, refresh1;
    logic [3:0] hour1;
    logic [5:0] minute1, seconds1;
    logic       sr_data1, sr_clk1, sr_latch1, busy1;

    tt_bin_clock_shift_out #(.CLK_DIV(4)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .hour_i(hour), .minute_i(minute),
        .seconds_i(seconds), .refresh_i(refresh), .sr_data_o(sr_data),
        .sr_clk_o(sr_clk), .sr_latch_o(sr_latch), .busy_o(busy)
    );

    tt_bin_clock_shift_out #(.CLK_DIV(1)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn1), .hour_i(hour1), .minute_i(minute1),
        .seconds_i(seconds1), .refresh_i(refresh1), .sr_data_o(sr_data1),
        .sr_clk_o(sr_clk1), .sr_latch_o(sr_latch1), .busy_o(busy1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_frame(input int h, input int m, input int s);
        int v;
        v = h * 4096 + m * 64 + s;
        return v[15:0];
    endfunction

    // External chain model for the CLK_DIV=4 instance
    logic        prev_clk = 1'b0, prev_latch = 1'b0, prev_busy = 1'b0;
    logic [15:0] acc = '0;
    int          bits_cur = 0, busy_len = 0, latch_len = 0, edges_total = 0;
    logic [15:0] frames_q[$];
    int          bits_q[$], latchw_q[$], runs_q[$];

    always @(negedge clk) begin
        if (!rstn) begin
            prev_clk <= 1'b0; prev_latch <= 1'b0; prev_busy <= 1'b0;
            acc <= '0; bits_cur <= 0; busy_len <= 0; latch_len <= 0;
        end else begin
            if (sr_clk && !prev_clk) begin
                acc <= {acc[14:0], sr_data};
                bits_cur <= bits_cur + 1;
                edges_total <= edges_total + 1;
            end
            if (sr_latch && !prev_latch) begin
                frames_q.push_back(acc);
                bits_q.push_back(bits_cur);
                bits_cur <= 0;
            end
            if (sr_latch) latch_len <= latch_len + 1;
            if (!sr_latch && prev_latch) begin
                latchw_q.push_back(latch_len);
                latch_len <= 0;
            end
            if (busy) busy_len <= busy_len + 1;
            if (!busy && prev_busy) begin
                runs_q.push_back(busy_len);
                busy_len <= 0;
            end
            prev_clk <= sr_clk; prev_latch <= sr_latch; prev_busy <= busy;
        end
    end

    // Same model for the CLK_DIV=1 instance, plus sr_clk toggle counting
    logic        prev_clk1 = 1'b0, prev_latch1 = 1'b0, prev_busy1 = 1'b0;
    logic [15:0] acc1 = '0;
    int          busy_len1 = 0, latch_len1 = 0, tog1 = 0;
    logic [15:0] frames1_q[$];
    int          latchw1_q[$], runs1_q[$], togs1_q[$];

    always @(negedge clk) begin
        if (!rstn1) begin
            prev_clk1 <= 1'b0; prev_latch1 <= 1'b0; prev_busy1 <= 1'b0;
            acc1 <= '0; busy_len1 <= 0; latch_len1 <= 0; tog1 <= 0;
        end else begin
            if (sr_clk1 && !prev_clk1) acc1 <= {acc1[14:0], sr_data1};
            if (sr_latch1 && !prev_latch1) frames1_q.push_back(acc1);
            if (sr_latch1) latch_len1 <= latch_len1 + 1;
            if (!sr_latch1 && prev_latch1) begin
                latchw1_q.push_back(latch_len1);
                latch_len1 <= 0;
            end
            if (busy1) begin
                busy_len1 <= busy_len1 + 1;
                if (sr_clk1 != prev_clk1) tog1 <= tog1 + 1;
            end
            if (!busy1 && prev_busy1) begin
                runs1_q.push_back(busy_len1);
                togs1_q.push_back(tog1);
                busy_len1 <= 0;
                tog1 <= 0;
            end
            prev_clk1 <= sr_clk1; prev_latch1 <= sr_latch1; prev_busy1 <= busy1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        cyc(1);
        refresh = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] expv);
        int k;
        k = 0;
        while (runs_q.size() == 0 && k < 2000) begin
            cyc(1);
            k++;
        end
        if (runs_q.size() == 0 || frames_q.size() == 0 || latchw_q.size() == 0) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " frame"}, frames_q.pop_front(), expv);
            check({tag, " bits"}, bits_q.pop_front(), 16);
            check({tag, " latch_w"}, latchw_q.pop_front(), 4);
            check({tag, " busy_len"}, runs_q.pop_front(), 133);
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        cyc(n);
        check({tag, " frames"}, frames_q.size(), 0);
        check({tag, " runs"}, runs_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, k, h, m, s, ph, pm, ps;
        logic chg, rf;

        rstn = 1'b0; refresh = 1'b0; hour = 4'd11; minute = 6'd30; seconds = 6'd45;
        rstn1 = 1'b0; refresh1 = 1'b0; hour1 = 4'd5; minute1 = 6'd42; seconds1 = 6'd17;
        cyc(3);
        check("rst sr_data", sr_data, 0);
        check("rst sr_clk", sr_clk, 0);
        check("rst sr_latch", sr_latch, 0);
        check("rst busy", busy, 0);

        // Boot frame from the pending flag set by reset
        rstn = 1'b1; rstn1 = 1'b1;
        expect_frame("boot", 16'hB7AD);

        k = 0;
        while (runs1_q.size() == 0 && k < 200) begin cyc(1); k++; end
        if (runs1_q.size() == 0 || frames1_q.size() == 0) begin
            check("div1 timeout", 32'd0, 32'd1);
        end else begin
            check("div1 frame", frames1_q.pop_front(), ref_frame(5, 42, 17));
            check("div1 busy_len", runs1_q.pop_front(), 34);
            check("div1 toggles", togs1_q.pop_front(), 32);
            check("div1 latch_w", latchw1_q.pop_front(), 1);
        end

        // Static inputs: nothing more goes out
        e0 = edges_total;
        cyc(1000);
        check("static edges", edges_total, e0);
        check("static runs", runs_q.size(), 0);

        // Input change mid-frame does not disturb the frame in flight
        pulse_refresh();
        cyc(40);
        seconds = 6'd46;
        expect_frame("midchg a", 16'hB7AD);
        expect_frame("midchg b", 16'hB7AE);
        expect_quiet("midchg", 300);

        // Three refreshes while busy collapse into one extra frame
        minute = 6'd31;
        cyc(10); pulse_refresh();
        cyc(20); pulse_refresh();
        cyc(20); pulse_refresh();
        expect_frame("multi a", ref_frame(11, 31, 46));
        expect_frame("multi b", ref_frame(11, 31, 46));
        expect_quiet("multi", 400);

        // Refresh together with an input change gives a single frame
        hour = 4'd3;
        pulse_refresh();
        expect_frame("coinc", ref_frame(3, 31, 46));
        expect_quiet("coinc", 300);

        // Reset in the middle of a frame
        pulse_refresh();
        k = 0;
        while (bits_cur != 7 && k < 500) begin cyc(1); k++; end
        check("abort reached bit7", bits_cur, 7);
        rstn = 1'b0;
        #1;
        check("abort sr_data", sr_data, 0);
        check("abort sr_clk", sr_clk, 0);
        check("abort sr_latch", sr_latch, 0);
        check("abort busy", busy, 0);
        cyc(10);
        check("abort frames", frames_q.size(), 0);
        check("abort latch", latchw_q.size(), 0);
        rstn = 1'b1;
        cyc(2);
        check("abort restart busy", busy, 1);
        expect_frame("abort fresh", ref_frame(3, 31, 46));
        expect_quiet("abort", 200);

        // Randomised raw values, including out-of-range ones
        ph = 3; pm = 31; ps = 46;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                h = 15; m = 63; s = 63; rf = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                h = ph; m = pm; s = ps; rf = 1'($urandom_range(0, 1));
            end else begin
                h = int'($urandom_range(0, 15));
                m = int'($urandom_range(0, 63));
                s = int'($urandom_range(0, 63));
                rf = 1'($urandom_range(0, 1));
            end
            chg = (h != ph) || (m != pm) || (s != ps);
            hour = h[3:0]; minute = m[5:0]; seconds = s[5:0];
            if (rf) pulse_refresh();
            if (chg || rf) expect_frame($sformatf("rand%0d", i), ref_frame(h, m, s));
            expect_quiet($sformatf("rand%0d", i), 150);
            ph = h; pm = m; ps = s;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
